// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op codes, FSM state encoding, counter helper.
// Latency: n/a (definitions only).  Backpressure: n/a.
package mdu_ctrl_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    // Busy lasts N cycles, so the down-counter is loaded with N-1.
    function automatic logic [3:0] cycles_to_count(input int n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: next {hi,lo} for op given operands and current HI/LO.
// Latency: 0 cycles.  Backpressure: none (pure function); MADD/MADDU only with MDU_MADD_EN.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        divisor;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Divide by one for the zero and INT_MIN/-1 cases: the zero result is discarded,
    // and INT_MIN/1 already yields the required quotient 0x8000_0000, remainder 0.
    assign div_zero = (src_b == 32'd0);
    assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign divisor  = (div_zero || div_ovf) ? 32'd1 : src_b;

    assign quo_s = $signed(src_a) / $signed(divisor);
    assign rem_s = $signed(src_a) % $signed(divisor);
    assign quo_u = src_a / divisor;
    assign rem_u = src_a % divisor;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (!div_zero) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            MDU_DIVU: begin
                if (!div_zero) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            MDU_MTHI:  res_hi = src_a;
            MDU_MTLO:  res_lo = src_a;
`ifdef MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            MDU_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: owns HI/LO, runs MULT/DIV for a fixed latency, MTHI/MTLO in one edge.
// Latency: MULT_CYCLES / DIV_CYCLES of busy, result visible as busy falls.
// Backpressure: busy stalls issue upstream; start while busy is ignored. Option: MDU_MADD_EN.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MUL_LOAD = cycles_to_count(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD = cycles_to_count(DIV_CYCLES);

    mdu_state_e  state_q;
    mdu_state_e  state_d;
    logic [3:0]  count_q;
    logic [3:0]  count_d;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        is_mul;
    logic        is_div;
    logic        is_mt;
    logic        load_pend;
    logic        commit;
    logic        mt_write;

    mdu_calc u_calc (
        .op     (mdu_op),
        .src_a  (srcA),
        .src_b  (srcB),
        .hi     (hi),
        .lo     (lo),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    always_comb begin
        is_mul = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (mdu_op == MDU_MADD) || (mdu_op == MDU_MADDU);
`endif
        is_div = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
        is_mt  = (mdu_op == MDU_MTHI) || (mdu_op == MDU_MTLO);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        load_pend = 1'b0;
        commit    = 1'b0;
        mt_write  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start && is_mul) begin
                    load_pend = 1'b1;
                    count_d   = MUL_LOAD;
                    state_d   = MDU_RUN;
                end else if (start && is_div) begin
                    load_pend = 1'b1;
                    count_d   = DIV_LOAD;
                    state_d   = MDU_RUN;
                end else if (start && is_mt) begin
                    mt_write  = 1'b1;
                end
            end
            MDU_RUN: begin
                if (count_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = MDU_IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            count_q <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (load_pend) begin
                pend_hi <= calc_hi;
                pend_lo <= calc_lo;
            end
            // HI/LO are frozen while running, so the pending value (captured from the
            // HI/LO-relative calc at start) is still correct at commit.
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (mt_write) begin
                hi <= calc_hi;
                lo <= calc_lo;
            end
        end
    end

    assign busy = (state_q == MDU_RUN);

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit and sequencer for the P6 pipelined MIPS core. Sits beside the ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, holds the architectural HI/LO registers, and raises `busy` for a fixed latency.
- The hazard unit stalls later MDU-class instructions in D while `start | busy`.

Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU; legal range 1..15.
- DIV_CYCLES, 10, busy duration of DIV/DIVU; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO; valid for one cycle.
- mdu_op  in  4  operation code, from the shared package.
- srcA  in  32  forwarded rs value.
- srcB  in  32  forwarded rt value.
- busy  out  1  multi-cycle operation in progress.
- hi  out  32  architectural HI, registered.
- lo  out  32  architectural LO, registered.

Behaviour:
- Reset (asynchronous assert, low): state=IDLE, count=0, busy=0, hi=0, lo=0, pending result regs=0. Reset asserted mid-operation aborts the operation immediately; HI/LO go to 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE with start=1, op MULT/MULTU/DIV/DIVU, at edge t:
  - Compute the result from srcA/srcB sampled at edge t into pend_hi/pend_lo.
  - Load count=N-1, where N is MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN: count decrements each edge. On the edge where count==0, commit pend_hi/pend_lo to hi/lo and return to IDLE.
  - busy is high for exactly N cycles (edges t+1..t+N).
  - New HI/LO are visible from edge t+N, the same edge busy falls.
- MTHI/MTLO with start=1 in IDLE:
  - hi (or lo) <= srcA at that edge, single cycle.
  - No busy assertion; the other register is unchanged.
- start=1 while busy=1 is a protocol violation (the hazard unit prevents it). Required response: ignore it; no state change, no HI/LO change.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 to 64.
  - MULTU: {hi,lo} = unsigned 32x32 to 64.
  - DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0.
  - Divide by zero (srcB==0): full latency runs; hi/lo are left unchanged at commit.
- Unknown mdu_op with start=1: no effect, busy stays 0.
- Reads of hi/lo are direct register outputs. MFHI/MFLO selection happens outside, in the EX mux.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds ops MADD and MADDU.
  - {hi,lo} <= {hi,lo} + signed (or unsigned) srcA*srcB, mod 2^64.
  - Latency is MULT_CYCLES. The accumulate base is the {hi,lo} value at commit time, which is the value at start because HI/LO cannot change while busy.
- Not defined: MADD/MADDU codes are treated as unknown ops (no effect).

Decomposition:
- Shared package/header (`head.v` style defines):
  - MDU op codes: MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MADD=7, MDU_MADDU=8.
  - State encodings MDU_IDLE and MDU_RUN.
- Sub-module mdu_calc: purely combinational; produces the pending 64-bit result from op, srcA, srcB, hi and lo.
- mdu_ctrl owns the FSM, the counter and the HI/LO registers.

Test Plan:
- Reset low mid-RUN (3 cycles into DIV) -> busy=0, hi=0, lo=0 immediately; after release, a new start is accepted.
- MULT srcA=0xFFFF_FFFE (-2), srcB=3 -> busy high exactly 5 cycles; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA at the 5th edge.
- MULTU srcA=0xFFFF_FFFF, srcB=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001 after 5 cycles.
- DIV srcA=0xFFFF_FFF9 (-7), srcB=2 -> busy 10 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU srcA=7, srcB=0 with hi=0x11, lo=0x22 beforehand -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MTHI srcA=0xDEAD_BEEF, then MULT started, then start pulses during busy -> hi=0xDEAD_BEEF next edge with busy=0; the during-busy starts are ignored and the result equals the first op only.
